product_bcd_converter: RTL and testbench
========================================

# product_bcd_converter

Sequential binary-to-BCD converter downstream of the 4×4 `multiplier`. It accepts the 8-bit product over a valid/ready handshake and runs an iterative double-dabble (shift-and-add-3) conversion. It then presents the packed decimal digits to the display/readout stage. One conversion is in flight at a time.

## Interface
Parameters:
- `WIDTH`, 8: binary input width (product width of the multiplier).
- `DIGITS`, 3: BCD output digits. It must satisfy 10^DIGITS > 2^WIDTH − 1.

Ports:
- `clk`  in  1: single clock. Everything is rising-edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: `in_product` is valid.
- `in_ready`  out  1: block can accept. High only in IDLE.
- `in_product`  in  WIDTH: binary product, e.g. `m_result`.
- `out_valid`  out  1: `out_bcd` holds a completed conversion.
- `out_ready`  in  1: consumer accepts `out_bcd`.
- `out_bcd`  out  4*DIGITS: packed BCD. Digit k is at bits [4k+3:4k], and digit 0 is the units digit.
- `busy`  out  1: high in SHIFT or DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE:** `in_ready`=1. On `in_valid`&&`in_ready` at an edge:
  - load the binary shift register with `in_product`;
  - clear the BCD scratch register;
  - load the iteration counter with WIDTH;
  - go to SHIFT.
- **SHIFT:** each cycle:
  - first, every scratch digit ≥5 gets +3 (4-bit add, no carry out);
  - then the {scratch, binary} register shifts left by 1;
  - the counter decrements.
- **SHIFT exit:** the edge that performs the last iteration (counter 1→0) writes the result to `out_bcd`, sets `out_valid`, and goes to DONE.
- **DONE:** `out_valid`=1 and `out_bcd` is held stable until `out_valid`&&`out_ready` at an edge. That edge clears `out_valid` and returns to IDLE.
- `out_bcd` keeps its last value after the handshake. It changes only when the next conversion completes.
- `in_product` is sampled only at the accept edge. Changes during SHIFT/DONE are ignored. `in_valid` outside IDLE is ignored, with no queuing.
- Arithmetic: the result is exact for 0..2^WIDTH−1. Digit values are always 0..9.

## Timing
- Reset values:
  - `in_ready`=1 once `rst_n` is high, and asserted 0 while in reset;
  - `out_valid`=0, `out_bcd`=0, `busy`=0;
  - counter=0, scratch/shift regs=0.
- `in_ready` and `busy` are decoded combinationally from the state register. `out_valid` and `out_bcd` are registered.
- Latency: with accept at edge 0, `out_valid` rises after edge WIDTH (8 cycles).
- Minimum issue interval is WIDTH+2 cycles: 1 accept cycle, WIDTH−1 further shift cycles, at least 1 DONE cycle, and 1 IDLE cycle. There is no accept in the same cycle as the output handshake.
- `out_ready` held high: DONE lasts exactly 1 cycle. `out_ready` low: DONE persists indefinitely with data stable.
- Reset mid-operation (any state): immediate return to IDLE. The partial result is discarded, and `out_valid` and `out_bcd` go to 0.
- Input value 0: still takes WIDTH cycles. There is no early exit.

## Structure
- Shared package `bcd_pkg`:
  - state enum typedef (IDLE/SHIFT/DONE);
  - `BCD_DIGIT_W`=4;
  - add-3 threshold constant (5);
  - a helper function computing the required DIGITS from WIDTH, for elaboration-time checks.
- Sub-module `bcd_add3`: combinational 4-bit digit correction cell (≥5 → +3), instantiated DIGITS times.
- Top level holds the FSM, counter (clog2(WIDTH+1) bits), the shift register, and the output registers.

## Test plan
- Reset, then idle: `in_ready`=1, `out_valid`=0, `out_bcd`=12'h000. Apply `in_product`=225 (15×15) with `out_ready`=1 → `out_valid` rises 8 cycles after accept, `out_bcd`=12'h225, back to IDLE.
- Sequence 0, 100, 9, 14, 255 with `out_ready`=1 → `out_bcd` 12'h000, 12'h100, 12'h009, 12'h014, 12'h255. Each issue is ≥10 cycles apart.
- Back-pressure: `in_product`=99 with `out_ready` held low 5 cycles after `out_valid` → `out_bcd`=12'h099 stable and `in_ready`=0 throughout. Handshake on release, then IDLE.
- Input disturbance: accept 63, then toggle `in_product` to 200 and keep `in_valid`=1 during SHIFT → result 12'h063. Only one accept occurs until IDLE is re-entered.
- Mid-conversion reset: accept 225 and drop `rst_n` at the 4th SHIFT cycle → asynchronous return to IDLE with all outputs 0. A subsequent conversion of 10 gives 12'h010.
- Exhaustive self-check: all 256 inputs against a decimal reference model. All digits ≤9 at every `out_valid`.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter and its digit cells.
package bcd_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_e;

   localparam int         BCD_DIGIT_W = 4;
   localparam logic [3:0] ADD3_THRESH = 4'd5;

   // Decimal digits needed to represent 2^width - 1.
   function automatic int bcd_digits_for(input int width);
      longint lim;
      longint pow10;
      int     d;
      lim   = (longint'(1) << width) - 1;
      pow10 = 10;
      d     = 1;
      while (pow10 <= lim) begin
         d++;
         pow10 = pow10 * 10;
      end
      return d;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] din,
   output logic [BCD_DIGIT_W-1:0] dout
);

   assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/product_bcd_converter.sv
// Iterative shift-and-add-3 converter: one WIDTH-bit product in, packed BCD digits out.
module product_bcd_converter
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_product,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
   output logic                          busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int BCD_W = BCD_DIGIT_W * DIGITS;

   generate
      if (DIGITS < bcd_digits_for(WIDTH)) begin : g_digits_chk
         $error("product_bcd_converter: DIGITS too small for WIDTH");
      end
   endgenerate

   bcd_state_e                            state;
   logic [CNT_W-1:0]                      cnt;
   logic [WIDTH-1:0]                      bin;
   logic [DIGITS-1:0][BCD_DIGIT_W-1:0]    scratch;
   logic [DIGITS-1:0][BCD_DIGIT_W-1:0]    adj;
   logic [BCD_W+WIDTH-1:0]                shifted;

   generate
      for (genvar d = 0; d < DIGITS; d++) begin : g_add3
         bcd_add3 u_add3 (
            .din  (scratch[d]),
            .dout (adj[d])
         );
      end
   endgenerate

   assign shifted  = {adj, bin} << 1;
   // in_ready is forced low while reset is held, not only after it releases.
   assign in_ready = rst_n && (state == IDLE);
   assign busy     = (state == SHIFT) || (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         bin       <= '0;
         scratch   <= '0;
         out_valid <= 1'b0;
         out_bcd   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  bin     <= in_product;
                  scratch <= '0;
                  cnt     <= CNT_W'(WIDTH);
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= shifted[BCD_W+WIDTH-1:WIDTH];
               bin     <= shifted[WIDTH-1:0];
               cnt     <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  out_bcd   <= shifted[BCD_W+WIDTH-1:WIDTH];
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Randomized and exhaustive check of product_bcd_converter against a decimal reference.
module tb_product_bcd_converter;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [WIDTH-1:0]      in_product = '0;
   logic                  out_valid;
   logic                  out_ready = 1'b1;
   logic [4*DIGITS-1:0]   out_bcd;
   logic                  busy;

   int n_chk  = 0;
   int n_fail = 0;

   product_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_product (in_product),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_bcd    (out_bcd),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   function automatic logic [4*DIGITS-1:0] bcd_ref(input int v);
      logic [4*DIGITS-1:0] r;
      int                  x;
      r = '0;
      x = v;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic run_conv(input int v, input int stall, input bit disturb);
      int                  n;
      logic [4*DIGITS-1:0] exp;
      exp = bcd_ref(v);
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("ready_wait", 32'(in_ready), 32'd1);
      in_product = WIDTH'(v);
      in_valid   = 1'b1;
      out_ready  = (stall == 0);
      @(posedge clk); #1;
      if (disturb) in_product = 8'd200;
      else         in_valid   = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         if (disturb) check("ready_low_shift", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
         if (!out_valid) n++;
         else break;
      end
      in_valid = 1'b0;
      check("latency", 32'(n), 32'(WIDTH));
      check("out_valid", 32'(out_valid), 32'd1);
      check("bcd", 32'(out_bcd), 32'(exp));
      for (int k = 0; k < DIGITS; k++)
         check("digit_le9", 32'(out_bcd[4*k +: 4] <= 4'd9), 32'd1);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_bcd", 32'(out_bcd), 32'(exp));
         check("stall_ready", 32'(in_ready), 32'd0);
         check("stall_busy", 32'(busy), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("hs_valid_clr", 32'(out_valid), 32'd0);
      check("hs_idle", 32'(in_ready), 32'd1);
      check("hs_not_busy", 32'(busy), 32'd0);
      check("hs_bcd_held", 32'(out_bcd), 32'(exp));
   endtask

   initial begin
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_bcd", 32'(out_bcd), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      #11 rst_n = 1'b1;
      #2;
      check("idle_ready", 32'(in_ready), 32'd1);
      check("idle_valid", 32'(out_valid), 32'd0);

      run_conv(225, 0, 1'b0);
      run_conv(0,   0, 1'b0);
      run_conv(100, 0, 1'b0);
      run_conv(9,   0, 1'b0);
      run_conv(14,  0, 1'b0);
      run_conv(255, 0, 1'b0);
      run_conv(99,  5, 1'b0);
      run_conv(63,  0, 1'b1);

      // Reset in the 4th SHIFT cycle of a conversion of 225.
      @(negedge clk);
      in_product = 8'd225;
      in_valid   = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_bcd", 32'(out_bcd), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_idle", 32'(in_ready), 32'd1);
      check("post_rst_valid", 32'(out_valid), 32'd0);
      run_conv(10, 0, 1'b0);

      for (int i = 0; i < 40; i++)
         run_conv(int'($urandom_range(255, 0)), int'($urandom_range(3, 0)), 1'(i % 7 == 3));

      for (int v = 0; v < 256; v++)
         run_conv(v, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, limit reached");
      $fatal(1, "timeout");
   end

endmodule
